// File: rtl/mem_readout_sched_pkg.sv
// Shared constants, FSM states and the port -> stream-mux select code table
// for the memory readout scheduler.
package mem_readout_pkg;

    localparam int NPORTS  = 12;
    localparam int ADDR_W  = 6;
    localparam int CNT_W   = ADDR_W + 1;
    localparam int RD_LAT  = 1;
    localparam int MAX_CYC = 108;
    localparam int CYC_W   = 7;

    localparam logic [CNT_W-1:0] MAX_ENT  = CNT_W'(64);
    localparam logic [3:0]       SEL_IDLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    // Codes 0, A and E are reserved by the downstream mux and never produced.
    function automatic logic [3:0] sel_code(input logic [3:0] port);
        logic [3:0] code;
        if (port <= 4'd8)
            code = port + 4'd1;
        else if (port <= 4'd11)
            code = port + 4'd2;
        else
            code = SEL_IDLE;
        return code;
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        return (c > MAX_ENT) ? MAX_ENT : c;
    endfunction

endpackage

// File: rtl/mem_readout_sched_if.sv
// Handshake/bus bundle between the readout scheduler and its environment.
interface mem_readout_sched_if;
    import mem_readout_pkg::*;

    logic                    start;
    logic [2:0]              bx_in;
    logic [NPORTS*CNT_W-1:0] nent;
    logic                    hold;
    logic [ADDR_W-1:0]       rd_addr;
    logic [2:0]              rd_bx;
    logic                    rd_en;
    logic [3:0]              sel;
    logic                    busy;
    logic                    done;
    logic                    trunc;

    modport master (
        output start, bx_in, nent, hold,
        input  rd_addr, rd_bx, rd_en, sel, busy, done, trunc
    );

    modport slave (
        input  start, bx_in, nent, hold,
        output rd_addr, rd_bx, rd_en, sel, busy, done, trunc
    );

endinterface

// File: rtl/mem_readout_sched_prio_pick.sv
// Lowest-set-bit priority encoder over the pending-port mask.
module prio_pick
    import mem_readout_pkg::*;
(
    input  logic [NPORTS-1:0] mask,
    output logic [3:0]        idx,
    output logic              valid
);

    // Scanning downwards lets the lowest set bit be the last (winning) write.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx   = 4'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_readout_sched.sv
// Per-BX readout scheduler: walks non-empty ports in priority order, issues
// shared read addresses and a latency-aligned mux select, within a cycle budget.
module mem_readout_sched
    import mem_readout_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mem_readout_sched_if.slave bus
);

    state_t             state_q, state_d;
    logic [3:0]         cur_q, cur_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [NPORTS-1:0]  pending_q, pending_d;
    logic [2:0]         bx_q, bx_d;
    logic               trunc_q, trunc_d;
    logic [CNT_W-1:0]   count_q [NPORTS];
    logic [CNT_W-1:0]   count_d [NPORTS];
    logic [CNT_W-1:0]   start_count [NPORTS];
    logic [NPORTS-1:0]  start_mask;
    logic [NPORTS-1:0]  cur_onehot;
    logic [NPORTS-1:0]  pick_mask;
    logic [3:0]         pick_idx;
    logic               pick_valid;
    logic               issue;
    logic               last_rd;
    logic [3:0]         sel_in;
    logic [3:0]         sel_pipe [RD_LAT];

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            start_count[k] = sat_count(bus.nent[k*CNT_W +: CNT_W]);
            start_mask[k]  = (start_count[k] != '0);
        end
    end

    // One encoder serves both a fresh start and the hand-over to the next port.
    assign cur_onehot = NPORTS'(1) << cur_q;
    assign pick_mask  = bus.start ? start_mask : (pending_q & ~cur_onehot);
    assign issue      = (state_q == READ) && !bus.hold && !bus.start;
    assign last_rd    = ({1'b0, addr_q} == (count_q[cur_q] - CNT_W'(1)));

    prio_pick u_pick (
        .mask  (pick_mask),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            addr_q    <= '0;
            cyc_q     <= '0;
            pending_q <= '0;
            bx_q      <= '0;
            trunc_q   <= 1'b0;
            for (int k = 0; k < NPORTS; k++) count_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            addr_q    <= addr_d;
            cyc_q     <= cyc_d;
            pending_q <= pending_d;
            bx_q      <= bx_d;
            trunc_q   <= trunc_d;
            for (int k = 0; k < NPORTS; k++) count_q[k] <= count_d[k];
        end
    end

    // start always wins, aborting any readout in flight without a done pulse.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        addr_d    = addr_q;
        cyc_d     = cyc_q;
        pending_d = pending_q;
        bx_d      = bx_q;
        trunc_d   = trunc_q;
        count_d   = count_q;
        if (bus.start) begin
            bx_d      = bus.bx_in;
            count_d   = start_count;
            pending_d = start_mask;
            cyc_d     = '0;
            trunc_d   = 1'b0;
            addr_d    = '0;
            cur_d     = pick_idx;
            state_d   = pick_valid ? READ : DONE;
        end else begin
            case (state_q)
                READ: begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (issue) begin
                        if (last_rd) begin
                            pending_d = pending_q & ~cur_onehot;
                            addr_d    = '0;
                            if (pick_valid) cur_d = pick_idx;
                            else            state_d = DONE;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                    if ((cyc_d == CYC_W'(MAX_CYC)) && (pending_d != '0)) begin
                        trunc_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        sel_in      = issue ? sel_code(cur_q) : SEL_IDLE;
        bus.rd_en   = issue;
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == DONE) && !bus.start;
        bus.rd_addr = addr_q;
        bus.rd_bx   = bx_q;
        bus.trunc   = trunc_q;
        bus.sel     = sel_pipe[RD_LAT-1];
    end

    // Select pipeline shifts every cycle so it stays aligned with memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) sel_pipe[i] <= SEL_IDLE;
        end else begin
            sel_pipe[0] <= sel_in;
            for (int i = 1; i < RD_LAT; i++) sel_pipe[i] <= sel_pipe[i-1];
        end
    end

endmodule
